// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave memory: programmable wait states, byte-lane writes and
// two-cycle ERROR responses for oversize, misaligned or out-of-range transfers.
module ahb_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclock,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    dphase_reg, dphase_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    write_reg, write_next;
  logic [2:0]              size_reg, size_next;

  logic                    accept;
  logic                    legal;
  logic [ADDR_WIDTH-1:0]   align_mask;
  logic                    oversize, misalign, out_of_range;
  logic                    complete;
  logic [IDX_W-1:0]        word_idx;
  logic [BPW-1:0]          lane_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  int                      lane_lo, lane_hi;

  // New address phases are only taken while the slave is showing ready.
  assign accept = hsel && hready && htrans[1] &&
                  ((state_reg == S_IDLE) || (state_reg == S_ERR2));

  assign align_mask   = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign oversize     = hsize > 3'(OFF_W);
  assign misalign     = |(haddr & align_mask);
  assign out_of_range = (haddr >> OFF_W) >= ADDR_WIDTH'(MEM_DEPTH);
  assign legal        = !(oversize || misalign || out_of_range);

  always_ff @(posedge hclock or negedge hresetn) begin
    if (!hresetn) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      dphase_reg <= 1'b0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      size_reg   <= 3'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dphase_reg <= dphase_next;
      addr_reg   <= addr_next;
      write_reg  <= write_next;
      size_reg   <= size_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dphase_next = dphase_reg;
    addr_next   = addr_reg;
    write_next  = write_reg;
    size_next   = size_reg;
    case (state_reg)
      S_IDLE, S_ERR2: begin
        state_next  = S_IDLE;
        dphase_next = 1'b0;
        if (accept) begin
          addr_next  = haddr;
          write_next = hwrite;
          size_next  = hsize;
          if (!legal) begin
            state_next = S_ERR1;
          end else begin
            dphase_next = 1'b1;
            if (WAIT_STATES > 0) begin
              state_next = S_WAIT;
              cnt_next   = 4'(WAIT_STATES);
            end
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) state_next = S_IDLE;
      end
      S_ERR1:  state_next = S_ERR2;
      default: state_next = S_IDLE;
    endcase
  end

  // An OKAY data phase finishes in the ready IDLE cycle that follows acceptance/waits.
  assign complete  = (state_reg == S_IDLE) && dphase_reg;
  assign hreadyout = (state_reg == S_IDLE) || (state_reg == S_ERR2);
  assign hresp     = (state_reg == S_ERR1) || (state_reg == S_ERR2);
  assign hrdata    = (complete && !write_reg) ? rd_word : '0;

  assign word_idx = addr_reg[OFF_W +: IDX_W];

  always_comb begin
    lane_en = '0;
    lane_lo = int'(addr_reg[OFF_W-1:0]);
    lane_hi = lane_lo + (1 << size_reg);
    for (int i = 0; i < BPW; i++) begin
      lane_en[i] = (i >= lane_lo) && (i < lane_hi);
    end
  end

  // One byte-wide array per lane so partial writes never touch neighbouring lanes.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];

      always_ff @(posedge hclock) begin
        if (complete && write_reg && lane_en[gi]) begin
          lane_mem[word_idx] <= hwdata[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, htrans[0], addr_reg};

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: three instances (0, 2 and 3 wait states) on a
// shared bus, directed checks then random transfers against a byte-level model.
module tb_ahb_lite_slave_mem;

  logic        hclock = 1'b0;
  logic        hresetn;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata_v [3];
  logic [2:0]  hreadyout_v;
  logic [2:0]  hresp_v;

  int n_cmp = 0;
  int n_err = 0;
  int ws_of [3] = '{0, 2, 3};
  logic [7:0] mdl [longint];

  always #5 hclock = ~hclock;
  assign hready = &hreadyout_v;

  ahb_lite_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .hclock(hclock), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hready(hready), .hwdata(hwdata), .hrdata(hrdata_v[0]),
    .hreadyout(hreadyout_v[0]), .hresp(hresp_v[0]));

  ahb_lite_slave_mem #(.WAIT_STATES(2)) u_ws2 (
    .hclock(hclock), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hready(hready), .hwdata(hwdata), .hrdata(hrdata_v[1]),
    .hreadyout(hreadyout_v[1]), .hresp(hresp_v[1]));

  ahb_lite_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .hclock(hclock), .hresetn(hresetn), .hsel(hsel_v[2]), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .htrans(htrans), .hready(hready), .hwdata(hwdata), .hrdata(hrdata_v[2]),
    .hreadyout(hreadyout_v[2]), .hresp(hresp_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] addr, input logic [2:0] size);
    longint a = longint'(addr);
    longint nb = longint'(1) << size;
    return (nb > 4) || (a % nb != 0) || (a / 4 >= 1024);
  endfunction

  function automatic longint key_of(input int inst, input logic [31:0] addr);
    return (longint'(inst) << 32) | longint'(addr);
  endfunction

  task automatic model_write(input int inst, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
    int nb = 1 << size;
    int off = int'(addr % 4);
    for (int b = 0; b < nb; b++)
      mdl[key_of(inst, addr + 32'(b))] = wdata[8*(off+b) +: 8];
  endtask

  task automatic model_read(input int inst, input logic [31:0] addr,
                            output logic [31:0] exp, output logic [31:0] mask);
    logic [31:0] base = addr & ~32'd3;
    exp = '0;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      if (mdl.exists(key_of(inst, base + 32'(b)))) begin
        exp[8*b +: 8]  = mdl[key_of(inst, base + 32'(b))];
        mask[8*b +: 8] = 8'hff;
      end
    end
  endtask

  task automatic bus_idle();
    hsel_v = '0;
    htrans = 2'd0;
  endtask

  // Single non-pipelined transfer; returns the final data-phase sample.
  task automatic xfer(input int inst, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp,
                      output logic first_resp, output int waits);
    bit first = 1'b1;
    @(posedge hclock); #1;
    hsel_v = '0;
    hsel_v[inst] = 1'b1;
    haddr = addr; hwrite = wr; hsize = size; htrans = 2'd2;
    @(posedge hclock); #1;
    bus_idle();
    hwdata = wdata;
    waits = 0;
    first_resp = 1'b0;
    forever begin
      @(negedge hclock);
      if (first) first_resp = hresp_v[inst];
      first = 1'b0;
      if (hreadyout_v[inst]) break;
      waits++;
      if (waits > 40) begin
        n_cmp++; n_err++;
        $error("FAIL timeout inst%0d: observed hreadyout low for %0d cycles expected <= 40", inst, waits);
        break;
      end
    end
    rdata = hrdata_v[inst];
    resp  = hresp_v[inst];
  endtask

  task automatic do_txn(input int inst, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    logic resp, first_resp, err;
    logic [31:0] exp, mask;
    int waits;
    string tag;
    tag = $sformatf("i%0d %s a=%h s=%0d", inst, wr ? "WR" : "RD", addr, size);
    err = is_err(addr, size);
    if (!wr && !err) model_read(inst, addr, exp, mask);
    xfer(inst, wr, addr, size, wdata, rdata, resp, first_resp, waits);
    chk({tag, " waits"}, 32'(waits), err ? 32'd1 : 32'(ws_of[inst]));
    chk({tag, " hresp"}, {31'd0, resp}, {31'd0, err});
    chk({tag, " first_hresp"}, {31'd0, first_resp}, {31'd0, err});
    if (err || wr) begin
      chk({tag, " hrdata_zero"}, rdata, 32'd0);
    end else if (mask != 0) begin
      chk({tag, " hrdata"}, rdata & mask, exp);
    end
    if (wr && !err) model_write(inst, addr, size, wdata);
    $display("txn %s wd=%h rd=%h waits=%0d resp=%0d", tag, wdata, rdata, waits, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    hresetn = 1'b0; hburst = 3'd0; hprot = 4'd0; haddr = '0; hwrite = 1'b0;
    hsize = 3'd2; hwdata = '0;
    bus_idle();

    // Reset state on every instance
    repeat (3) @(posedge hclock);
    @(negedge hclock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset i%0d hreadyout", i), {31'd0, hreadyout_v[i]}, 32'd1);
      chk($sformatf("reset i%0d hresp", i), {31'd0, hresp_v[i]}, 32'd0);
      chk($sformatf("reset i%0d hrdata", i), hrdata_v[i], 32'd0);
    end
    @(posedge hclock); #1;
    hresetn = 1'b1;

    // BUSY/IDLE with hsel, then NONSEQ without hsel: nothing is accepted.
    // An oversize hsize would show as ERROR if it were wrongly accepted.
    for (int p = 0; p < 3; p++) begin
      @(posedge hclock); #1;
      hsel_v = (p == 2) ? 3'b000 : 3'b111;
      htrans = (p == 0) ? 2'd1 : (p == 1) ? 2'd0 : 2'd2;
      haddr = 32'h40; hwrite = 1'b0; hsize = 3'd3;
      @(posedge hclock); #1;
      bus_idle();
      @(negedge hclock);
      chk($sformatf("idle p%0d hreadyout", p), {29'd0, hreadyout_v}, 32'd7);
      chk($sformatf("idle p%0d hresp", p), {29'd0, hresp_v}, 32'd0);
      chk($sformatf("idle p%0d hrdata", p), hrdata_v[0] | hrdata_v[1] | hrdata_v[2], 32'd0);
      $display("txn idle pattern %0d htrans=%0d", p, (p == 0) ? 1 : (p == 1) ? 0 : 2);
    end

    // Zero-wait back-to-back write then read of the same address
    @(posedge hclock); #1;
    hsel_v = 3'b001; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    @(posedge hclock); #1;
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(negedge hclock);
    chk("b2b write hreadyout", {31'd0, hreadyout_v[0]}, 32'd1);
    @(posedge hclock); #1;
    bus_idle();
    @(negedge hclock);
    chk("b2b read hreadyout", {31'd0, hreadyout_v[0]}, 32'd1);
    chk("b2b read hresp", {31'd0, hresp_v[0]}, 32'd0);
    chk("b2b read hrdata", hrdata_v[0], 32'hDEADBEEF);
    model_write(0, 32'h40, 3'd2, 32'hDEADBEEF);
    $display("txn b2b i0 WR/RD a=00000040 rd=%h", hrdata_v[0]);

    // Byte lanes
    do_txn(0, 1'b1, 32'h80, 3'd2, 32'h11223344, rd);
    do_txn(0, 1'b1, 32'h81, 3'd0, 32'h5A5AAA5A, rd);
    do_txn(0, 1'b0, 32'h80, 3'd2, 32'h0, rd);
    chk("byte lane merge", rd, 32'h1122AA44);

    // Wait states
    do_txn(1, 1'b1, 32'h20, 3'd2, 32'hC0FFEE11, rd);
    do_txn(1, 1'b0, 32'h20, 3'd2, 32'h0, rd);
    chk("ws2 read data", rd, 32'hC0FFEE11);

    // Errors leave memory alone
    do_txn(0, 1'b1, 32'h0, 3'd2, 32'hA5A5A5A5, rd);
    do_txn(0, 1'b1, 32'h3, 3'd1, 32'hFFFFFFFF, rd);
    do_txn(0, 1'b1, 32'h1000, 3'd2, 32'h0BADF00D, rd);
    do_txn(0, 1'b1, 32'h80, 3'd3, 32'hFFFFFFFF, rd);
    do_txn(1, 1'b1, 32'h23, 3'd1, 32'hFFFFFFFF, rd);
    do_txn(0, 1'b0, 32'h0, 3'd2, 32'h0, rd);
    chk("err word0 intact", rd, 32'hA5A5A5A5);
    do_txn(0, 1'b0, 32'h80, 3'd2, 32'h0, rd);
    do_txn(1, 1'b0, 32'h20, 3'd2, 32'h0, rd);

    // Reset in the middle of a waited write aborts the commit
    do_txn(2, 1'b1, 32'h10, 3'd2, 32'h12345678, rd);
    @(posedge hclock); #1;
    hsel_v = 3'b100; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    @(posedge hclock); #1;
    bus_idle();
    hwdata = 32'hCAFEF00D;
    @(negedge hclock);
    chk("midwait hreadyout", {31'd0, hreadyout_v[2]}, 32'd0);
    #1 hresetn = 1'b0;
    #1;
    chk("async reset hreadyout", {31'd0, hreadyout_v[2]}, 32'd1);
    chk("async reset hresp", {31'd0, hresp_v[2]}, 32'd0);
    @(posedge hclock); #1;
    hresetn = 1'b1;
    $display("txn reset during WAIT on i2");
    do_txn(2, 1'b0, 32'h10, 3'd2, 32'h0, rd);
    chk("aborted write", rd, 32'h12345678);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int inst = int'($urandom_range(0, 2));
      logic wr = 1'($urandom_range(0, 1));
      logic [2:0] sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      logic [31:0] a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 19) == 0) a = a + 32'h1000;
      do_txn(inst, wr, a, sz, $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_slave_mem.md
# ahb_lite_slave_mem

Parametrised AHB-Lite slave memory with programmable wait states, byte-lane writes and two-cycle ERROR responses. It sits on the slave side of the AHB interface and is the responder the AHB-Lite master VIP runs against. Unlike a fixed zero-wait responder, it scales in address width, data width and depth, and it checks transfer legality.

## Interface
- ADDR_WIDTH, 32, haddr width
- DATA_WIDTH, 32, hwdata/hrdata width; legal values are 32, 64 and 128
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words
- WAIT_STATES, 0, cycles of hreadyout=0 inserted in every OKAY data phase; range 0..15
- hclock  input  1  bus clock; all state changes on the rising edge
- hresetn  input  1  asynchronous, active-low reset
- hsel  input  1  slave select
- haddr  input  ADDR_WIDTH  byte address
- hwrite  input  1  1=write, 0=read
- hsize  input  3  transfer size, 2^hsize bytes
- hburst  input  3  ignored; each beat is decoded on its own
- hprot  input  4  ignored
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hready  input  1  bus-level ready; address phase is sampled only when this is 1
- hwdata  input  DATA_WIDTH  write data, data phase
- hrdata  output  DATA_WIDTH  read data, valid when hreadyout=1 in a read data phase
- hreadyout  output  1  slave ready
- hresp  output  1  0=OKAY, 1=ERROR

## Operation
- Accept: the address phase is accepted when hsel && hready && htrans[1] are all true at a rising edge. The block then registers haddr, hwrite and hsize.
- IDLE/BUSY, or hsel=0: no data phase; hreadyout=1, hresp=0.
- Legality of an accepted transfer:
  - ERROR if 2^hsize > DATA_WIDTH/8.
  - ERROR if haddr is not aligned to 2^hsize.
  - ERROR if the word index haddr/(DATA_WIDTH/8) >= MEM_DEPTH.
  - Otherwise OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hreadyout=1.
    - Accepted legal transfer with WAIT_STATES>0 -> WAIT, with cnt=WAIT_STATES.
    - Accepted legal transfer with WAIT_STATES=0 -> stay in IDLE, data phase active.
    - Accepted illegal transfer -> ERR1.
  - WAIT: hreadyout=0, hresp=0, cnt decrements. At cnt==1 -> IDLE, and the data phase completes next cycle.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE. A transfer presented in this cycle is accepted as usual.
- Error transfers insert no wait states.
- Write commit:
  - Happens on the edge where hreadyout=1 ends an OKAY write data phase.
  - Only byte lanes [addr_q%BPW +: 2^hsize_q] of mem[word_q] are updated, using hwdata on those lanes.
  - Erroring writes never modify memory.
- Read:
  - hrdata = mem[word_q], full word on all lanes, driven during an OKAY read data phase.
  - hrdata = 0 otherwise, including ERROR responses.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, cnt=0. Reset takes effect immediately and asynchronously.
- Reset mid data phase: the phase is aborted and no write is committed.
- Latency: an OKAY transfer accepted at edge N completes at edge N+1+WAIT_STATES.
- ERROR: hreadyout is low for one cycle, then high for one cycle; hresp=1 in both cycles.
- Back-to-back: the next address phase overlaps the completing data phase. A read of a just-written address returns the new data, because the write commits before the read's data phase.
- While hreadyout=0, hready is low at the bus, so no new address phase is accepted.
- Aliases: hrdata, hreadyout and hresp are decoded combinationally from registered state and mem.

## Test plan
- Reset:
  - Stimulus: assert hresetn=0 with the bus idle.
  - Required: hreadyout=1, hresp=0, hrdata=0.
  - Stimulus: a NONSEQ write to 0x10 followed by a mid-WAIT reset with WAIT_STATES=3.
  - Required: a later read of 0x10 does not return that data.
- Zero wait:
  - Stimulus: write 0xDEADBEEF to 0x40, then immediately read 0x40.
  - Required: each data phase has hreadyout=1, and the read returns 0xDEADBEEF one cycle after its address phase.
- Byte lanes:
  - Stimulus: write word 0x11223344 to 0x80, then byte 0xAA to 0x81 (hsize=0), then read 0x80.
  - Required: read returns 0x1122AA44.
- Wait states:
  - Stimulus: WAIT_STATES=2, read.
  - Required: hreadyout=0 for exactly 2 cycles, then 1 with data and hresp=0.
- Error:
  - Stimulus 1: hsize=1 to 0x03 (misaligned).
  - Stimulus 2: word address MEM_DEPTH (out of range).
  - Stimulus 3: hsize=3 with DATA_WIDTH=32 (oversize).
  - Required for each: hreadyout goes 0 then 1 with hresp=1 in both cycles, and memory is unchanged.
- IDLE/BUSY:
  - Stimulus: htrans=1 or 0 with hsel=1, then htrans=2 with hsel=0.
  - Required: no state change, hreadyout stays 1, hresp stays 0.
